// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit start validation,
// centre sampling of data/stop bits, one-cycle valid / framing-error strobes.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       serial_dat_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       receiving
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          sync_q;
   logic          rx_s_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          dv_q, dv_d;
   logic          fe_q, fe_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q  <= 1'b1;
         rx_s_q  <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         sync_q  <= serial_dat_in;
         rx_s_q  <= sync_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         fe_q    <= fe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  dv_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            // a line held low must rise before a new start bit can be seen
            if (rx_s_q) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign data_out   = data_q;
   assign data_valid = dv_q;
   assign frame_err  = fe_q;
   assign receiving  = (state_q != IDLE);

endmodule
